weprom_sched: RTL

- Round-robin write scheduler that shares one serial EPROM writer between NREQ requesters.
- Takes a parallel 8-bit address and 8-bit data word from the granted requester.
- Frames both words as 12-bit words (header 4'b1000 + payload), sends them MSB-first on the writer's address/data lines under cs, then waits for the writer's ack and for its serial output to drain.
- Retries on missing ack and reports done or err back to the requester.

---
 rtl/weprom_sched_if.sv | 28 ++
 rtl/weprom_sched.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/weprom_sched_if.sv
// Requester and serial-writer signal bundle for weprom_sched.
// master: scheduler side.  slave: requesters plus EPROM writer side.
interface weprom_sched_if #(
    parameter int NREQ = 2
);
    logic [NREQ-1:0]   req;
    logic [NREQ*8-1:0] req_addr;
    logic [NREQ*8-1:0] req_data;
    logic [NREQ-1:0]   gnt;
    logic [NREQ-1:0]   done;
    logic [NREQ-1:0]   err;
    logic              cs;
    logic              address;
    logic              data;
    logic              ack;
    logic              out_vaild;
    logic              busy;

    modport master (
        input  req, req_addr, req_data, ack, out_vaild,
        output gnt, done, err, cs, address, data, busy
    );

    modport slave (
        output req, req_addr, req_data, ack, out_vaild,
        input  gnt, done, err, cs, address, data, busy
    );
endinterface

// File: rtl/weprom_sched.sv
// Round-robin scheduler sharing one serial EPROM writer between NREQ
// requesters. The granted requester's address and data bytes are framed as
// {4'b1000, byte}, shifted out MSB-first under cs, then the scheduler waits
// for the writer's ack and for its serial output to drain. Missing acks are
// retried up to MAX_RETRY times; the outcome is returned as a done or err
// pulse to the granted requester.
module weprom_sched #(
    parameter int NREQ        = 2,
    parameter int LEAD        = 3,
    parameter int ACK_TIMEOUT = 16,
    parameter int OUT_TIMEOUT = 80,
    parameter int MAX_RETRY   = 2,
    parameter int GAP         = 2
) (
    input logic            clk,
    input logic            rst,
    weprom_sched_if.master bus
);
    localparam int FRAME_LEN = LEAD + 12;
    localparam int CMAX1     = (FRAME_LEN > ACK_TIMEOUT) ? FRAME_LEN : ACK_TIMEOUT;
    localparam int CMAX2     = (CMAX1 > OUT_TIMEOUT) ? CMAX1 : OUT_TIMEOUT;
    localparam int CMAX      = (CMAX2 > GAP) ? CMAX2 : GAP;
    localparam int CW        = $clog2(CMAX + 1);
    localparam int PW        = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int RW        = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [CW-1:0] FRAME_LAST = CW'(FRAME_LEN - 1);
    localparam logic [CW-1:0] ACK_LAST   = CW'(ACK_TIMEOUT - 1);
    localparam logic [CW-1:0] OUT_LAST   = CW'(OUT_TIMEOUT - 1);
    localparam logic [CW-1:0] GAP_LAST   = CW'(GAP - 1);
    localparam logic [RW-1:0] RETRY_MAX  = RW'(MAX_RETRY);
    localparam logic [3:0]    HDR        = 4'b1000;

    typedef enum logic [2:0] {
        IDLE,
        ARB,
        FRAME,
        WAIT_ACK,
        GAP_RETRY,
        WAIT_OUT,
        GAP_END
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [PW-1:0]   ptr;
    logic [RW-1:0]   retry;
    logic [11:0]     addr_frame;
    logic [11:0]     data_frame;
    logic [11:0]     addr_sh;
    logic [11:0]     data_sh;
    logic            ov_seen;

    logic [PW-1:0]   win;
    logic            win_found;
    logic [NREQ-1:0] win_onehot;
    logic [PW-1:0]   scan;
    logic [7:0]      sel_addr;
    logic [7:0]      sel_data;
    logic [11:0]     next_addr;
    logic [11:0]     next_data;
    logic            frame_start;

    // Round-robin pick starting just after the last winner, plus the frame
    // source for the next FRAME entry (fresh words from ARB, latched on retry).
    always_comb begin
        win        = '0;
        win_found  = 1'b0;
        win_onehot = '0;
        scan       = '0;
        for (int unsigned i = 1; i <= NREQ; i++) begin
            scan = PW'((32'(ptr) + i) % NREQ);
            if (!win_found && bus.req[scan]) begin
                win_found = 1'b1;
                win       = scan;
            end
        end
        win_onehot[win] = 1'b1;
        sel_addr        = bus.req_addr[32'(win) * 8 +: 8];
        sel_data        = bus.req_data[32'(win) * 8 +: 8];
        next_addr       = (state == ARB) ? {HDR, sel_addr} : addr_frame;
        next_data       = (state == ARB) ? {HDR, sel_data} : data_frame;
        frame_start     = ((state == ARB) && win_found) ||
                          ((state == GAP_RETRY) && (cnt == GAP_LAST));
    end

    // Transaction FSM; every output is a register updated here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            ptr         <= PW'(NREQ - 1);
            retry       <= '0;
            addr_frame  <= '0;
            data_frame  <= '0;
            addr_sh     <= '0;
            data_sh     <= '0;
            ov_seen     <= 1'b0;
            bus.gnt     <= '0;
            bus.done    <= '0;
            bus.err     <= '0;
            bus.cs      <= 1'b0;
            bus.address <= 1'b0;
            bus.data    <= 1'b0;
            bus.busy    <= 1'b0;
        end else begin
            bus.done <= '0;
            bus.err  <= '0;
            cnt      <= (cnt == '1) ? cnt : cnt + 1'b1;

            case (state)
                IDLE: begin
                    if (|bus.req) begin
                        state    <= ARB;
                        bus.busy <= 1'b1;
                    end
                end

                ARB: begin
                    if (win_found) begin
                        state      <= FRAME;
                        ptr        <= win;
                        retry      <= '0;
                        bus.gnt    <= win_onehot;
                        addr_frame <= {HDR, sel_addr};
                        data_frame <= {HDR, sel_data};
                    end else begin
                        state    <= IDLE;
                        bus.busy <= 1'b0;
                    end
                end

                FRAME: begin
                    if (cnt == FRAME_LAST) begin
                        state       <= WAIT_ACK;
                        cnt         <= '0;
                        bus.cs      <= 1'b0;
                        bus.address <= 1'b0;
                        bus.data    <= 1'b0;
                    end else if (32'(cnt) + 32'd1 >= 32'(LEAD)) begin
                        // Shift one cycle ahead so bit 11 appears exactly at c = LEAD.
                        bus.address <= addr_sh[11];
                        bus.data    <= data_sh[11];
                        addr_sh     <= {addr_sh[10:0], 1'b0};
                        data_sh     <= {data_sh[10:0], 1'b0};
                    end
                end

                WAIT_ACK: begin
                    if (bus.ack) begin
                        state   <= WAIT_OUT;
                        cnt     <= '0;
                        ov_seen <= 1'b0;
                    end else if (cnt == ACK_LAST) begin
                        cnt <= '0;
                        if (retry < RETRY_MAX) begin
                            retry <= retry + 1'b1;
                            state <= GAP_RETRY;
                        end else begin
                            bus.err <= bus.gnt;
                            state   <= GAP_END;
                        end
                    end
                end

                GAP_RETRY: begin
                    if (cnt == GAP_LAST) begin
                        state <= FRAME;
                    end
                end

                WAIT_OUT: begin
                    ov_seen <= ov_seen | bus.out_vaild;
                    if (ov_seen && !bus.out_vaild) begin
                        bus.done <= bus.gnt;
                        state    <= GAP_END;
                        cnt      <= '0;
                    end else if (cnt == OUT_LAST) begin
                        bus.err <= bus.gnt;
                        state   <= GAP_END;
                        cnt     <= '0;
                    end
                end

                GAP_END: begin
                    // gnt is still high during the done/err cycle, dropped after it.
                    bus.gnt <= '0;
                    if (cnt == GAP_LAST) begin
                        state    <= IDLE;
                        bus.busy <= 1'b0;
                    end
                end

                default: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
            endcase

            // Common FRAME entry for first attempt and retries.
            if (frame_start) begin
                cnt    <= '0;
                bus.cs <= 1'b1;
                if (LEAD == 0) begin
                    bus.address <= next_addr[11];
                    bus.data    <= next_data[11];
                    addr_sh     <= {next_addr[10:0], 1'b0};
                    data_sh     <= {next_data[10:0], 1'b0};
                end else begin
                    bus.address <= 1'b0;
                    bus.data    <= 1'b0;
                    addr_sh     <= next_addr;
                    data_sh     <= next_data;
                end
            end
        end
    end
endmodule
